// File: rtl/systolic_west_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_west_feeder
// Purpose  : West-edge feeder for a systolic array. Takes one activation
//            vector per beat over valid/ready and emits per-row skewed
//            {input, valid, switch} streams. Row r lags row 0 by r cycles.
//            Each tile is preceded by one switch-only token so every PE row
//            promotes its background weight one cycle before its first beat.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            flush           - synchronous clear of pipeline and FSM
//            in_valid/ready  - upstream handshake
//            in_data         - ROWS lanes, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//            in_last         - last beat of the tile
//            out_input       - per-row activation, same packing as in_data
//            out_valid       - per-row valid
//            out_switch      - per-row weight-switch flag
//            busy            - FSM outside IDLE
//            tile_done       - pulse while row ROWS-1 presents the last beat
// Revision : 1.0 - initial release
// ============================================================================
module systolic_west_feeder #(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] out_input,
  output logic [ROWS-1:0]            out_valid,
  output logic [ROWS-1:0]            out_switch,
  output logic                       busy,
  output logic                       tile_done
);

  localparam int c_cnt_w = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_drain_cnt;
  logic [c_cnt_w-1:0]   w_drain_cnt_nxt;

  // Token injected into every lane at the coming edge.
  logic                       w_accept;
  logic                       w_inj_valid;
  logic                       w_inj_switch;
  logic                       w_inj_last;
  logic [ROWS*DATA_WIDTH-1:0] w_inj_data;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and injection control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_accept        = 1'b0;
    w_inj_valid     = 1'b0;
    w_inj_switch    = 1'b0;
    w_inj_last      = 1'b0;
    in_ready        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The pending beat is left in place; it is taken in STREAM.
        if (in_valid) begin
          w_state_nxt = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        w_inj_switch = 1'b1;
        w_state_nxt  = ST_STREAM;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_inj_valid = 1'b1;
          if (in_last) begin
            w_inj_last = 1'b1;
            // Single-row arrays have nothing left to drain.
            if (ROWS == 1) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt     = ST_DRAIN;
              w_drain_cnt_nxt = c_cnt_w'(ROWS - 1);
            end
          end
        end
      end
      ST_DRAIN: begin
        // Leaves after ROWS-1 cycles, once the counter steps to zero.
        w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        if (r_drain_cnt <= c_cnt_w'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_inj_data = w_accept ? in_data : '0;
  assign busy       = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Per-lane delay lines: lane r has r+1 stages, last stage drives row r.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_data [0:r];
    logic [r:0]            r_valid;
    logic [r:0]            r_switch;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= r; s++) begin
          r_data[s] <= '0;
        end
        r_valid  <= '0;
        r_switch <= '0;
      end else if (flush) begin
        for (int s = 0; s <= r; s++) begin
          r_data[s] <= '0;
        end
        r_valid  <= '0;
        r_switch <= '0;
      end else begin
        r_data[0]   <= w_inj_data[r*DATA_WIDTH +: DATA_WIDTH];
        r_valid[0]  <= w_inj_valid;
        r_switch[0] <= w_inj_switch;
        for (int s = 1; s <= r; s++) begin
          r_data[s]   <= r_data[s-1];
          r_valid[s]  <= r_valid[s-1];
          r_switch[s] <= r_switch[s-1];
        end
      end
    end

    assign out_input[r*DATA_WIDTH +: DATA_WIDTH] = r_data[r];
    assign out_valid[r]                          = r_valid[r];
    assign out_switch[r]                         = r_switch[r];
  end

  // --------------------------------------------------------------------------
  // Last-beat marker travels alongside lane ROWS-1 so tile_done lines up with
  // that row presenting the final beat. Cleared on abort, so no pulse follows.
  // --------------------------------------------------------------------------
  logic [ROWS-1:0] r_last_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_pipe <= '0;
    end else if (flush) begin
      r_last_pipe <= '0;
    end else begin
      r_last_pipe[0] <= w_inj_last;
      for (int s = 1; s < ROWS; s++) begin
        r_last_pipe[s] <= r_last_pipe[s-1];
      end
    end
  end

  assign tile_done = r_last_pipe[ROWS-1];

endmodule
`default_nettype wire

// File: tb/tb_systolic_west_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_west_feeder
// Purpose  : Directed, table-driven bench for systolic_west_feeder (ROWS=2,
//            DATA_WIDTH=16) with hand-written async-reset abort sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_west_feeder;

  localparam int ROWS = 2;
  localparam int DW   = 16;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ROWS*DW-1:0] in_data;
  logic               in_last;
  logic [ROWS*DW-1:0] out_input;
  logic [ROWS-1:0]    out_valid;
  logic [ROWS-1:0]    out_switch;
  logic               busy;
  logic               tile_done;

  systolic_west_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_input  (out_input),
    .out_valid  (out_valid),
    .out_switch (out_switch),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        vld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        last;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic [1:0]  e_valid;
    logic [1:0]  e_switch;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic fl, input logic v, input int d0,
                              input int d1, input logic l, input logic er,
                              input logic eb, input logic ed,
                              input logic [1:0] ev, input logic [1:0] es,
                              input int e0, input int e1);
    vec_t t;
    t.flush = fl; t.vld = v; t.d0 = 16'(d0); t.d1 = 16'(d1); t.last = l;
    t.e_ready = er; t.e_busy = eb; t.e_done = ed;
    t.e_valid = ev; t.e_switch = es; t.e0 = 16'(e0); t.e1 = 16'(e1);
    return t;
  endfunction

  // Packs {in_ready, busy, tile_done, out_valid, out_switch, out_input}.
  function automatic logic [38:0] snap();
    return {in_ready, busy, tile_done, out_valid, out_switch, out_input};
  endfunction

  task automatic check(input string name, input logic [38:0] exp);
    logic [38:0] got;
    got = snap();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b busy=%b done=%b vld=%b sw=%b in=%h, expected rdy=%b busy=%b done=%b vld=%b sw=%b in=%h",
               name, got[38], got[37], got[36], got[35:34], got[33:32], got[31:0],
               exp[38], exp[37], exp[36], exp[35:34], exp[33:32], exp[31:0]);
    end
  endtask

  initial begin
    //              fl v   d0      d1     l  rdy bsy dn  vld    sw     e0      e1
    // Two-beat tile straight out of reset
    vecs[0]  = mk(0, 1,      3,    -5, 0,  0,  1,  0, 2'b00, 2'b00,      0,      0);
    vecs[1]  = mk(0, 1,      3,    -5, 0,  1,  1,  0, 2'b00, 2'b01,      0,      0);
    vecs[2]  = mk(0, 1,      3,    -5, 0,  1,  1,  0, 2'b01, 2'b10,      3,      0);
    vecs[3]  = mk(0, 1,      7,     9, 1,  0,  1,  0, 2'b11, 2'b00,      7,     -5);
    vecs[4]  = mk(0, 0,      0,     0, 0,  0,  0,  1, 2'b10, 2'b00,      0,      9);
    vecs[5]  = mk(0, 0,      0,     0, 0,  0,  0,  0, 2'b00, 2'b00,      0,      0);
    // Bubble between beats
    vecs[6]  = mk(0, 1,      1,     2, 0,  0,  1,  0, 2'b00, 2'b00,      0,      0);
    vecs[7]  = mk(0, 1,      1,     2, 0,  1,  1,  0, 2'b00, 2'b01,      0,      0);
    vecs[8]  = mk(0, 1,      1,     2, 0,  1,  1,  0, 2'b01, 2'b10,      1,      0);
    vecs[9]  = mk(0, 0,      0,     0, 0,  1,  1,  0, 2'b10, 2'b00,      0,      2);
    vecs[10] = mk(0, 1,      4,     5, 1,  0,  1,  0, 2'b01, 2'b00,      4,      0);
    // Back-to-back tile with signed extremes, in_valid held high
    vecs[11] = mk(0, 1, -32768, 32767, 0,  0,  0,  1, 2'b10, 2'b00,      0,      5);
    vecs[12] = mk(0, 1, -32768, 32767, 0,  0,  1,  0, 2'b00, 2'b00,      0,      0);
    vecs[13] = mk(0, 1, -32768, 32767, 0,  1,  1,  0, 2'b00, 2'b01,      0,      0);
    vecs[14] = mk(0, 1, -32768, 32767, 0,  1,  1,  0, 2'b01, 2'b10, -32768,      0);
    vecs[15] = mk(0, 1,  32767,-32768, 1,  0,  1,  0, 2'b11, 2'b00,  32767,  32767);
    vecs[16] = mk(0, 0,      0,     0, 0,  0,  0,  1, 2'b10, 2'b00,      0, -32768);
    vecs[17] = mk(0, 0,      0,     0, 0,  0,  0,  0, 2'b00, 2'b00,      0,      0);
    // Flush mid-tile (flush wins over an accepting last beat)
    vecs[18] = mk(0, 1,     11,    12, 0,  0,  1,  0, 2'b00, 2'b00,      0,      0);
    vecs[19] = mk(0, 1,     11,    12, 0,  1,  1,  0, 2'b00, 2'b01,      0,      0);
    vecs[20] = mk(0, 1,     11,    12, 0,  1,  1,  0, 2'b01, 2'b10,     11,      0);
    vecs[21] = mk(1, 1,     13,    14, 1,  0,  0,  0, 2'b00, 2'b00,      0,      0);
    vecs[22] = mk(0, 0,      0,     0, 0,  0,  0,  0, 2'b00, 2'b00,      0,      0);
    // Single-beat tile
    vecs[23] = mk(0, 1,      6,    -6, 1,  0,  1,  0, 2'b00, 2'b00,      0,      0);
    vecs[24] = mk(0, 1,      6,    -6, 1,  1,  1,  0, 2'b00, 2'b01,      0,      0);
    vecs[25] = mk(0, 1,      6,    -6, 1,  0,  1,  0, 2'b01, 2'b10,      6,      0);
    vecs[26] = mk(0, 0,      0,     0, 0,  0,  0,  1, 2'b10, 2'b00,      0,     -6);
    vecs[27] = mk(0, 0,      0,     0, 0,  0,  0,  0, 2'b00, 2'b00,      0,      0);

    // Reset held with in_valid high: everything must stay at zero.
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = {16'hFFFB, 16'h0003};
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 39'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      flush    = vecs[i].flush;
      in_valid = vecs[i].vld;
      in_data  = {vecs[i].d1, vecs[i].d0};
      in_last  = vecs[i].last;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_valid,
             vecs[i].e_switch, vecs[i].e1, vecs[i].e0});
      @(negedge clk);
    end

    // Async reset mid-tile: one beat in flight, rst_n pulsed between edges.
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = {16'd22, 16'd21};
    in_last  = 1'b0;
    @(posedge clk); #1;
    check("abort_switch_state", {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0});
    @(posedge clk); #1;
    check("abort_stream_state", {1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 32'd0});
    @(posedge clk); #1;
    check("abort_beat_row0", {1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 16'd0, 16'd21});
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_async_clear", 39'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_quiet%0d", k), 39'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
